// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM state
// encoding and the alignment/legality rule used at request acceptance.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RD    = 2'b01,
      ST_RWAIT = 2'b10,
      ST_WR    = 2'b11
   } lsu_state_e;

   // True when the access can not be performed: illegal size code, a half
   // on an odd address, or a word that is not 4-byte aligned.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = offset[0];
         SZ_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for the load/store unit.
//  - Load side: pick the byte/half addressed by offset (little-endian) out
//    of a memory word and sign- or zero-extend it.
//  - Store side: merge right-aligned sub-word data into the addressed lane
//    of the old memory word, leaving every other bit untouched.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] ld_word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] st_old_word,
   input  logic [31:0] st_new_data,
   output logic [31:0] ld_data,
   output logic [31:0] st_merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Byte lane selected by the two low address bits.
   always_comb begin
      byte_lane = 8'h00;
      case (offset)
         2'b00:   byte_lane = ld_word[7:0];
         2'b01:   byte_lane = ld_word[15:8];
         2'b10:   byte_lane = ld_word[23:16];
         2'b11:   byte_lane = ld_word[31:24];
         default: byte_lane = 8'h00;
      endcase
   end

   // Half lane selected by address bit 1 (bit 0 is zero for legal halves).
   always_comb begin
      half_lane = 16'h0000;
      if (offset[1]) begin
         half_lane = ld_word[31:16];
      end else begin
         half_lane = ld_word[15:0];
      end
   end

   // Extend the selected lane to a full word according to size and signedness.
   always_comb begin
      ld_data = ld_word;
      case (size)
         SZ_BYTE: begin
            if (is_unsigned) begin
               ld_data = {24'h000000, byte_lane};
            end else begin
               ld_data = {{24{byte_lane[7]}}, byte_lane};
            end
         end
         SZ_HALF: begin
            if (is_unsigned) begin
               ld_data = {16'h0000, half_lane};
            end else begin
               ld_data = {{16{half_lane[15]}}, half_lane};
            end
         end
         default: ld_data = ld_word;
      endcase
   end

   // Read-modify-write merge: only the addressed lane takes new data.
   always_comb begin
      st_merged = st_old_word;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'b00:   st_merged[7:0]   = st_new_data[7:0];
               2'b01:   st_merged[15:8]  = st_new_data[7:0];
               2'b10:   st_merged[23:16] = st_new_data[7:0];
               2'b11:   st_merged[31:24] = st_new_data[7:0];
               default: st_merged        = st_old_word;
            endcase
         end
         SZ_HALF: begin
            if (offset[1]) begin
               st_merged[31:16] = st_new_data[15:0];
            end else begin
               st_merged[15:0]  = st_new_data[15:0];
            end
         end
         SZ_WORD: st_merged = st_new_data;
         default: st_merged = st_old_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-only synchronous memory.
// Loads:            IDLE -> RD -> RWAIT -> IDLE   (response 2 edges after accept)
// Word stores:      IDLE -> WR -> IDLE            (response 1 edge after accept)
// Sub-word stores:  IDLE -> RD -> RWAIT -> WR -> IDLE (response 3 edges after)
// Faulting requests never leave IDLE and answer on the accepting edge.
// All outputs are registered; memory enables are decoded from the next state
// so they are high exactly while the FSM sits in RD or WR.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_read_en,
   output logic              mem_write_en,
   input  logic [31:0]       mem_rdata
);

   lsu_state_e  state;
   lsu_state_e  state_next;

   // Request fields captured at acceptance and held for the whole access.
   logic        op_we;
   logic [1:0]  op_size;
   logic        op_unsigned;
   logic [1:0]  op_offset;
   logic [31:0] op_wdata;

   logic        capture;
   logic        rsp_valid_next;
   logic        rsp_fault_next;
   logic [31:0] rsp_rdata_next;
   logic [31:0] mem_wdata_next;

   logic [31:0] ld_data;
   logic [31:0] st_merged;

   lsu_lane_align u_align (
      .ld_word     (mem_rdata),
      .offset      (op_offset),
      .size        (op_size),
      .is_unsigned (op_unsigned),
      .st_old_word (mem_rdata),
      .st_new_data (op_wdata),
      .ld_data     (ld_data),
      .st_merged   (st_merged)
   );

   // FSM state register; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_next     = state;
      capture        = 1'b0;
      rsp_valid_next = 1'b0;
      rsp_fault_next = 1'b0;
      rsp_rdata_next = 32'h0000_0000;
      mem_wdata_next = mem_wdata;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  // Fault answers immediately and touches no memory.
                  rsp_valid_next = 1'b1;
                  rsp_fault_next = 1'b1;
               end else begin
                  capture = 1'b1;
                  if (req_we && (req_size == SZ_WORD)) begin
                     state_next     = ST_WR;
                     mem_wdata_next = req_wdata;
                  end else begin
                     // Loads and sub-word stores both need the old word.
                     state_next = ST_RD;
                  end
               end
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RD: begin
            state_next = ST_RWAIT;
         end
         ST_RWAIT: begin
            // mem_rdata is valid now: either merge for a store or answer a load.
            if (op_we) begin
               state_next     = ST_WR;
               mem_wdata_next = st_merged;
            end else begin
               state_next     = ST_IDLE;
               rsp_valid_next = 1'b1;
               rsp_rdata_next = ld_data;
            end
         end
         ST_WR: begin
            state_next     = ST_IDLE;
            rsp_valid_next = 1'b1;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Capture of the accepted request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_we       <= 1'b0;
         op_size     <= SZ_BYTE;
         op_unsigned <= 1'b0;
         op_offset   <= 2'b00;
         op_wdata    <= 32'h0000_0000;
      end else if (capture) begin
         op_we       <= req_we;
         op_size     <= req_size;
         op_unsigned <= req_unsigned;
         op_offset   <= req_addr[1:0];
         op_wdata    <= req_wdata;
      end
   end

   // Registered outputs: handshake, response and memory interface.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_fault    <= 1'b0;
         rsp_rdata    <= 32'h0000_0000;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_addr     <= {ADDR_W{1'b0}};
         mem_wdata    <= 32'h0000_0000;
      end else begin
         req_ready    <= (state_next == ST_IDLE);
         mem_read_en  <= (state_next == ST_RD);
         mem_write_en <= (state_next == ST_WR);
         rsp_valid    <= rsp_valid_next;
         rsp_fault    <= rsp_fault_next;
         rsp_rdata    <= rsp_rdata_next;
         mem_wdata    <= mem_wdata_next;
         // Word address is held from RD through WR.
         if (capture) begin
            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level reference
// model: a reference memory plus a per-cycle schedule of expected enables,
// handshake and responses derived from the access timing rules.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [31:0] mem_rdata = 32'h0;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_fault    (rsp_fault),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   // Word memory: 1-cycle synchronous read, write has priority, plus a preload port.
   logic [31:0] mem [64];
   logic        pre_we = 1'b0;
   logic [5:0]  pre_idx = 6'd0;
   logic [31:0] pre_data = 32'h0;
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_addr[7:2]] <= mem_wdata;
      else if (mem_read_en) mem_rdata <= mem[mem_addr[7:2]];
      if (pre_we) mem[pre_idx] <= pre_data;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference state
   logic [31:0] ref_mem [64];
   typedef struct { int cyc; logic [31:0] data; bit fault; } rsp_t;
   rsp_t rq[$];
   bit          exp_busy [int];
   bit          exp_re   [int];
   logic [31:0] exp_wd   [int];
   logic [31:0] exp_ma   [int];
   typedef struct { string name; logic [31:0] act; logic [31:0] exp; } pc_t;
   pc_t pend[$];
   bit  mon_on = 1'b0;

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] m_load(logic [31:0] w, logic [1:0] off, logic [1:0] sz, bit uns);
      logic [31:0] v;
      int sh;
      sh = 8 * int'(off);
      v = w >> sh;
      if (sz == 2'd0) begin
         v = v & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = v & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_merge(logic [31:0] old, logic [31:0] nd, logic [1:0] off, logic [1:0] sz);
      logic [31:0] mask;
      int sh;
      if (sz == 2'd2) return nd;
      sh = 8 * int'(off);
      mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      return (old & ~mask) | ((nd << sh) & mask);
   endfunction

   function automatic bit m_fault(logic [1:0] sz, logic [1:0] off);
      return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
   endfunction

   function automatic void push(string n, logic [31:0] a, logic [31:0] e);
      pc_t p;
      p.name = n; p.act = a; p.exp = e;
      pend.push_back(p);
   endfunction

   function automatic void cmp(string nm, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, a, e);
      end
   endfunction

   // The single compare process: per-cycle schedule checks plus queued side checks.
   always @(negedge clk) begin
      while (pend.size() > 0) begin
         pc_t p;
         p = pend.pop_front();
         cmp(p.name, p.act, p.exp);
      end
      if (mon_on) begin
         cmp("req_ready", {31'b0, req_ready}, exp_busy.exists(cyc) ? 32'd0 : 32'd1);
         cmp("mem_read_en", {31'b0, mem_read_en}, exp_re.exists(cyc) ? 32'd1 : 32'd0);
         cmp("mem_write_en", {31'b0, mem_write_en}, exp_wd.exists(cyc) ? 32'd1 : 32'd0);
         cmp("enables_exclusive", {31'b0, mem_read_en & mem_write_en}, 32'd0);
         if (exp_re.exists(cyc) || exp_wd.exists(cyc)) cmp("mem_addr", mem_addr, exp_ma[cyc]);
         if (exp_wd.exists(cyc)) cmp("mem_wdata", mem_wdata, exp_wd[cyc]);
         if (rq.size() > 0 && rq[0].cyc < cyc) begin
            cmp("rsp_missing", 32'd0, 32'd1);
            void'(rq.pop_front());
         end
         if (rsp_valid) begin
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
               cmp("rsp_rdata", rsp_rdata, rq[0].data);
               cmp("rsp_fault", {31'b0, rsp_fault}, {31'b0, rq[0].fault});
               void'(rq.pop_front());
            end else begin
               cmp("rsp_unexpected", 32'd1, 32'd0);
            end
         end
      end
   end

   // Present a request, wait for acceptance, and schedule what must follow.
   task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, output int c0);
      int n;
      logic [5:0] idx;
      logic [1:0] off;
      rsp_t r;
      req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 64) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 64) begin
         push("req_ready_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         c0 = -1;
         return;
      end
      @(posedge clk); #1;
      c0 = cyc;
      req_valid = 1'b0;
      idx = addr[7:2];
      off = addr[1:0];
      r.data = 32'h0; r.fault = 1'b0;
      if (m_fault(sz, off)) begin
         r.cyc = c0; r.fault = 1'b1;
      end else if (!we) begin
         exp_busy[c0] = 1'b1; exp_busy[c0+1] = 1'b1;
         exp_re[c0] = 1'b1; exp_ma[c0] = {addr[31:2], 2'b00};
         r.cyc = c0 + 2; r.data = m_load(ref_mem[idx], off, sz, uns);
      end else if (sz == 2'd2) begin
         exp_busy[c0] = 1'b1;
         exp_wd[c0] = wd; exp_ma[c0] = {addr[31:2], 2'b00};
         ref_mem[idx] = wd;
         r.cyc = c0 + 1;
      end else begin
         for (int k = 0; k < 3; k++) exp_busy[c0+k] = 1'b1;
         exp_re[c0] = 1'b1; exp_ma[c0] = {addr[31:2], 2'b00};
         ref_mem[idx] = m_merge(ref_mem[idx], wd, off, sz);
         exp_wd[c0+2] = ref_mem[idx]; exp_ma[c0+2] = {addr[31:2], 2'b00};
         r.cyc = c0 + 3;
      end
      rq.push_back(r);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((rq.size() != 0 || pend.size() != 0) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) push("idle_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int c0;
      logic [31:0] saved;
      bit we, uns;
      logic [1:0] sz, off;
      int r;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 64; i++) begin
         pre_we = 1'b1; pre_idx = 6'(i);
         pre_data = (i == 4) ? 32'h8844_22F1 : $urandom;
         ref_mem[i] = pre_data;
         @(posedge clk); #1;
      end
      pre_we = 1'b0;
      push("rst_req_ready", {31'b0, req_ready}, 32'd1);
      push("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      push("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
      push("rst_rsp_rdata", rsp_rdata, 32'd0);
      push("rst_enables", {30'b0, mem_read_en, mem_write_en}, 32'd0);
      push("rst_mem_addr", mem_addr, 32'd0);
      push("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      mon_on = 1'b1;

      // Model pins against hand-computed values
      push("pin_sb_0x11", m_load(32'h8844_22F1, 2'd1, 2'd0, 1'b0), 32'h0000_0022);
      push("pin_sb_0x10", m_load(32'h8844_22F1, 2'd0, 2'd0, 1'b0), 32'hFFFF_FFF1);
      push("pin_ub_0x10", m_load(32'h8844_22F1, 2'd0, 2'd0, 1'b1), 32'h0000_00F1);
      push("pin_sh_0x12", m_load(32'h8844_22F1, 2'd2, 2'd1, 1'b0), 32'hFFFF_8844);
      push("pin_merge_half", m_merge(32'h8844_22F1, 32'h0000_BEEF, 2'd2, 2'd1), 32'hBEEF_22F1);
      push("pin_merge_byte", m_merge(32'h8844_22F1, 32'h0000_0077, 2'd3, 2'd0), 32'h7744_22F1);

      // Directed loads and half store at 0x10
      issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, c0);
      issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, c0);
      issue(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, c0);
      issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, c0);
      wait_idle();
      push("mem_0x10_after_half", mem[4], 32'hBEEF_22F1);

      // Word store then back-to-back word load
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, c0);
      issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, c0);
      wait_idle();
      push("mem_0x20_word", mem[8], 32'hDEAD_BEEF);

      // Faults
      issue(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, c0);
      issue(1'b1, 2'd1, 1'b0, 32'h13, 32'h1234_5678, c0);
      issue(1'b0, 2'd3, 1'b0, 32'h14, 32'h0, c0);
      issue(1'b1, 2'd3, 1'b0, 32'h18, 32'hFFFF_FFFF, c0);
      wait_idle();
      push("mem_0x20_after_faults", mem[8], 32'hDEAD_BEEF);

      // Reset during RWAIT of a sub-word store
      saved = ref_mem[5];
      issue(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000_00A5, c0);
      @(posedge clk); #2;
      rst = 1'b1;
      ref_mem[5] = saved;
      rq.delete(); exp_busy.delete(); exp_re.delete(); exp_wd.delete(); exp_ma.delete();
      #1;
      push("midrst_req_ready", {31'b0, req_ready}, 32'd1);
      push("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      push("midrst_enables", {30'b0, mem_read_en, mem_write_en}, 32'd0);
      push("midrst_mem_addr", mem_addr, 32'd0);
      push("midrst_mem_wdata", mem_wdata, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      push("midrst_mem_unchanged", mem[5], saved);

      // Random back-to-back traffic
      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         off = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) off[0] = 1'b0;
            if (sz == 2'd2) off = 2'd0;
         end
         issue(we, sz, uns, {24'h0, 6'($urandom_range(0, 63)), off}, $urandom, c0);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
      end
      wait_idle();
      for (int i = 0; i < 64; i++) push("final_mem", mem[i], ref_mem[i]);
      wait_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
